frame_stream_tx: RTL and testbench
==================================

Name: frame_stream_tx

Overview:
Transmit end of the pixel-stream interface: reads a stored frame from a synchronous frame memory in raster order and emits it as a continuous one-pixel-per-clock stream with Frame/Line strobes.
The stream is directly consumable by the coordinate-recovering output handler.
The block sits between a frame buffer (test pattern or processed image) and any block that consumes the Pixel/Frame/Line stream.

Parameters:
PW, 8, pixel width in bits
COLS, 160, pixels per line (1..256)
ROWS, 120, lines per frame (1..256)

Ports:
Clk  input  1  clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  single-cycle request to send one frame; sampled in IDLE only
Continuous  input  1  when high, frames repeat back-to-back with no gap
RdEn  output  1  memory read strobe (registered)
RdCol  output  8  memory column address (registered)
RdRow  output  8  memory row address (registered)
RdData  input  PW  memory read data, valid the cycle after RdEn
Pixel  output  PW  stream pixel (registered)
Frame  output  1  high with pixel (0,0) of each frame
Line  output  1  high with pixel (0,j) for j>=1
Busy  output  1  high from first read issue through last pixel out
FrameDone  output  1  single-cycle pulse coincident with last pixel of a frame

Behaviour:
- Reset (async, Reset=1):
  - State=IDLE; all outputs 0; address counters 0; pipeline valid/strobe bits cleared.
  - Reset mid-frame aborts immediately; no partial-frame completion after release.
- Stream protocol:
  - One pixel per clock, no gaps within a frame.
  - Frame=1 only with pixel (0,0).
  - Line=1 only with the first pixel of rows 1..ROWS-1.
  - Never Frame and Line together.
  - Outside a frame: Pixel=0, Frame=0, Line=0.
- States:
  - IDLE: waits for Start=1.
  - SEND: issues one read per cycle in raster order, col fastest.
  - DRAIN: last read issued; waits for the 2-cycle pipeline to empty.
- IDLE -> SEND on Start:
  - Cycle t: Start sampled.
  - t+1: RdEn=1, RdCol=0, RdRow=0; Busy rises.
- Address sequence:
  - col increments each cycle; wraps COLS-1 -> 0 with row+1.
  - At (COLS-1, ROWS-1) the last read is issued.
  - If Continuous=1 in that cycle, next cycle issues (0,0) and stays in SEND. Otherwise go to DRAIN with RdEn=0.
- Pipeline:
  - Stage 1 tags each issued read with isFirst (0,0) / isLineStart (col=0, row>0) / isLast.
  - Stage 2 registers RdData into Pixel with the matching strobes.
  - Latency from read issue to Pixel out = 2 cycles, so Frame appears at t+3 after Start.
- Frame timing:
  - Last pixel appears at t+2+COLS*ROWS with FrameDone=1.
  - Busy falls the cycle after (DRAIN -> IDLE).
  - In Continuous mode Busy stays high and Frame of the next frame immediately follows the FrameDone cycle.
- Continuous deasserted mid-frame: current frame completes normally, then stop.
- Start while Busy: ignored.
- Start in the same cycle as DRAIN -> IDLE: ignored; must be re-issued in IDLE.
- Width rules:
  - Counters 8-bit.
  - Compare against COLS-1/ROWS-1 only, never rely on natural overflow; COLS=256 or ROWS=256 must work.
- Degenerate sizes:
  - ROWS=1: no Line strobes ever.
  - COLS=1: every pixel after the first carries Line.

Test Plan:
- COLS=4, ROWS=3, memory holds value 16*row+col; Start pulse at t -> Frame=1 with Pixel=0x00 at t+3. Pixels 00,01,02,03,10,11,12,13,20,21,22,23 on consecutive cycles. Line=1 with 0x10 and 0x20. FrameDone=1 with 0x23 at t+14. Busy high t+1..t+14.
- Same config, Continuous=1 for two frames -> 24 contiguous pixels. Frame=1 at t+3 and t+15. FrameDone at t+14 and t+26. No idle cycle between frames.
- Start re-pulsed at t+5 during a frame -> stream identical to the single-frame case; no second frame.
- Reset asserted at t+7, released at t+9 -> Pixel/Frame/Line/Busy/RdEn are 0 from t+7 onward. No FrameDone. Next Start produces a clean frame beginning with (0,0).
- COLS=1, ROWS=3 -> Frame with 0x00, Line with 0x10 and 0x20, FrameDone with 0x20.
- Back-to-back check against the output handler: its recovered coordinates (i,j) equal (col,row) of each transmitted pixel for a full 160x120 frame.

Source files
------------

// File: rtl/frame_stream_tx.sv
// frame_stream_tx: reads a stored frame from a synchronous frame memory in raster
// order and emits it as a gap-free one-pixel-per-clock stream with Frame/Line strobes.
//
// Ports:
//   Clk        - clock, all logic on rising edge
//   Reset      - asynchronous active-high reset
//   Start      - single-cycle request to send one frame (honoured in IDLE only)
//   Continuous - repeat frames back-to-back while high
//   RdEn       - memory read strobe
//   RdCol      - memory column address
//   RdRow      - memory row address
//   RdData     - memory read data, valid the cycle after RdEn
//   Pixel      - stream pixel
//   Frame      - high with pixel (0,0)
//   Line       - high with the first pixel of rows 1..ROWS-1
//   Busy       - high from first read issue through last pixel out
//   FrameDone  - pulse with the last pixel of a frame
module frame_stream_tx #(
    parameter int unsigned PW   = 8,
    parameter int unsigned COLS = 160,
    parameter int unsigned ROWS = 120
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Continuous,
    output logic          RdEn,
    output logic [7:0]    RdCol,
    output logic [7:0]    RdRow,
    input  logic [PW-1:0] RdData,
    output logic [PW-1:0] Pixel,
    output logic          Frame,
    output logic          Line,
    output logic          Busy,
    output logic          FrameDone
);

    localparam int unsigned AW = 8;
    localparam logic [AW-1:0] LAST_COL = AW'(COLS - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;

    // Stage-1 tags travelling alongside the outstanding memory read
    logic s1_valid;
    logic s1_first;
    logic s1_line_start;
    logic s1_last;

    logic at_last_col;
    logic at_last_row;
    logic at_col_zero;
    logic at_row_zero;

    // Explicit end-of-range compares so COLS/ROWS of 256 never depend on wraparound
    assign at_last_col = (RdCol == LAST_COL);
    assign at_last_row = (RdRow == LAST_ROW);
    assign at_col_zero = (RdCol == '0);
    assign at_row_zero = (RdRow == '0);

    // Control FSM: owns the read address counters, RdEn and Busy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            RdEn  <= 1'b0;
            RdCol <= '0;
            RdRow <= '0;
            Busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= SEND;
                        RdEn  <= 1'b1;
                        RdCol <= '0;
                        RdRow <= '0;
                        Busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (at_last_col && at_last_row) begin
                        RdCol <= '0;
                        RdRow <= '0;
                        // Continuous sampled on the last read decides whether the next frame follows
                        if (!Continuous) begin
                            state <= DRAIN;
                            RdEn  <= 1'b0;
                        end
                    end else if (at_last_col) begin
                        RdCol <= '0;
                        RdRow <= RdRow + AW'(1);
                    end else begin
                        RdCol <= RdCol + AW'(1);
                    end
                end
                DRAIN: begin
                    // Once stage 1 is empty the last pixel is being registered out
                    if (!s1_valid) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    RdEn  <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: tag each issued read while the memory fetches its data
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_line_start <= 1'b0;
            s1_last       <= 1'b0;
        end else begin
            s1_valid      <= RdEn;
            s1_first      <= RdEn && at_col_zero && at_row_zero;
            s1_line_start <= RdEn && at_col_zero && !at_row_zero;
            s1_last       <= RdEn && at_last_col && at_last_row;
        end
    end

    // Stage 2: register memory data with its strobes; zero outside a frame
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Pixel     <= '0;
            Frame     <= 1'b0;
            Line      <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            Pixel     <= s1_valid ? RdData : '0;
            Frame     <= s1_valid && s1_first;
            Line      <= s1_valid && s1_line_start;
            FrameDone <= s1_valid && s1_last;
        end
    end

endmodule

// File: tb/tb_frame_stream_tx.sv
// Bench for frame_stream_tx: table-driven 4x3 frames, hand sequences for reset abort
// and a 1-column frame, and a randomized 160x120 run against an interval-based model.
module tb_frame_stream_tx;

    localparam int unsigned PW     = 8;
    localparam int unsigned A_COLS = 4;
    localparam int unsigned A_ROWS = 3;
    localparam int unsigned A_N    = A_COLS * A_ROWS;
    localparam int unsigned C_COLS = 160;
    localparam int unsigned C_ROWS = 120;
    localparam int          C_N    = C_COLS * C_ROWS;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    // Instance A: 4x3
    logic          a_start, a_cont, a_rden, a_frame, a_line, a_busy, a_done;
    logic [7:0]    a_rdcol, a_rdrow;
    logic [PW-1:0] a_rddata, a_pixel;
    // Instance B: 1x3
    logic          b_start, b_cont, b_rden, b_frame, b_line, b_busy, b_done;
    logic [7:0]    b_rdcol, b_rdrow;
    logic [PW-1:0] b_rddata, b_pixel;
    // Instance C: 160x120
    logic          c_start, c_cont, c_rden, c_frame, c_line, c_busy, c_done;
    logic [7:0]    c_rdcol, c_rdrow;
    logic [PW-1:0] c_rddata, c_pixel;

    frame_stream_tx #(.PW(PW), .COLS(A_COLS), .ROWS(A_ROWS)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(a_start), .Continuous(a_cont),
        .RdEn(a_rden), .RdCol(a_rdcol), .RdRow(a_rdrow), .RdData(a_rddata),
        .Pixel(a_pixel), .Frame(a_frame), .Line(a_line), .Busy(a_busy), .FrameDone(a_done));

    frame_stream_tx #(.PW(PW), .COLS(1), .ROWS(3)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(b_start), .Continuous(b_cont),
        .RdEn(b_rden), .RdCol(b_rdcol), .RdRow(b_rdrow), .RdData(b_rddata),
        .Pixel(b_pixel), .Frame(b_frame), .Line(b_line), .Busy(b_busy), .FrameDone(b_done));

    frame_stream_tx #(.PW(PW), .COLS(C_COLS), .ROWS(C_ROWS)) dut_c (
        .Clk(Clk), .Reset(Reset), .Start(c_start), .Continuous(c_cont),
        .RdEn(c_rden), .RdCol(c_rdcol), .RdRow(c_rdrow), .RdData(c_rddata),
        .Pixel(c_pixel), .Frame(c_frame), .Line(c_line), .Busy(c_busy), .FrameDone(c_done));

    function automatic int mem_c(int col, int row);
        return (37 * row + col) & 8'hFF;
    endfunction

    // Synchronous frame memories: data one cycle after the read strobe
    always @(posedge Clk) begin
        if (a_rden) a_rddata <= PW'(16 * int'(a_rdrow) + int'(a_rdcol));
        if (b_rden) b_rddata <= PW'(16 * int'(b_rdrow) + int'(b_rdcol));
        if (c_rden) c_rddata <= PW'(mem_c(int'(c_rdcol), int'(c_rdrow)));
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic start;
        logic cont;
        int   pixel;
        logic frame;
        logic line;
        logic done;
        logic busy;
        logic rden;
    } vec_t;

    vec_t vec[$];

    // Vector i drives inputs during cycle t+i and expects the outputs of cycle t+i+1
    task automatic build_table(input int nf, input int repulse_at);
        vec_t v;
        int   c, k;
        vec.delete();
        for (int i = 0; i < int'(A_N) * nf + 4; i++) begin
            c = i + 1;
            k = c - 3;
            v.start = (i == 0) || (i == repulse_at);
            v.cont  = (nf > 1) && (i <= int'(A_N) * (nf - 1));
            v.pixel = 0; v.frame = 0; v.line = 0; v.done = 0;
            if (k >= 0 && k < int'(A_N) * nf) begin
                k = k % int'(A_N);
                v.pixel = 16 * (k / int'(A_COLS)) + (k % int'(A_COLS));
                v.frame = (k == 0);
                v.line  = (k != 0) && (k % int'(A_COLS) == 0);
                v.done  = (k == int'(A_N) - 1);
            end
            v.busy = (c <= int'(A_N) * nf + 2);
            v.rden = (c <= int'(A_N) * nf);
            vec.push_back(v);
        end
    endtask

    task automatic run_table(input string name);
        foreach (vec[i]) begin
            a_start = vec[i].start;
            a_cont  = vec[i].cont;
            step();
            chk($sformatf("%s[%0d].pixel", name, i), int'(a_pixel), vec[i].pixel);
            chk($sformatf("%s[%0d].frame", name, i), int'(a_frame), int'(vec[i].frame));
            chk($sformatf("%s[%0d].line",  name, i), int'(a_line),  int'(vec[i].line));
            chk($sformatf("%s[%0d].done",  name, i), int'(a_done),  int'(vec[i].done));
            chk($sformatf("%s[%0d].busy",  name, i), int'(a_busy),  int'(vec[i].busy));
            chk($sformatf("%s[%0d].rden",  name, i), int'(a_rden),  int'(vec[i].rden));
        end
        a_start = 1'b0;
        a_cont  = 1'b0;
    endtask

    task automatic chk_a_quiet(input string name);
        chk({name, ".pixel"}, int'(a_pixel), 0);
        chk({name, ".frame"}, int'(a_frame), 0);
        chk({name, ".line"},  int'(a_line),  0);
        chk({name, ".done"},  int'(a_done),  0);
        chk({name, ".busy"},  int'(a_busy),  0);
        chk({name, ".rden"},  int'(a_rden),  0);
    endtask

    // Reference for C: each frame is the interval of reads starting at cycle s
    int starts[$];

    function automatic bit model_busy(int c);
        foreach (starts[i]) if (c >= starts[i] && c <= starts[i] + C_N + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_rden(int c);
        foreach (starts[i]) if (c >= starts[i] && c <= starts[i] + C_N - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_k(int c);
        foreach (starts[i]) if (c - 2 - starts[i] >= 0 && c - 2 - starts[i] < C_N) return c - 2 - starts[i];
        return -1;
    endfunction

    initial begin
        int cyc, k, rec_i, rec_j;
        a_start = 0; a_cont = 0; b_start = 0; b_cont = 0; c_start = 0; c_cont = 0;

        // Reset state
        repeat (3) step();
        chk_a_quiet("reset_a");
        chk("reset_b.busy", int'(b_busy), 0);
        chk("reset_c.busy", int'(c_busy), 0);
        chk("reset_c.rdcol", int'(c_rdcol), 0);
        Reset = 1'b0;
        repeat (2) step();

        // Single frame
        build_table(1, -1);
        run_table("single");

        // Two continuous frames
        build_table(2, -1);
        run_table("cont2");

        // Start re-pulsed mid-frame is ignored
        build_table(1, 5);
        run_table("repulse");

        // Reset abort at t+7, release at t+9
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (6) step();
        chk("abort.pre_line", int'(a_line), 1);
        chk("abort.pre_pixel", int'(a_pixel), 8'h10);
        Reset = 1'b1;
        #1;
        chk_a_quiet("abort.t7");
        step();
        chk_a_quiet("abort.t8");
        step();
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_a_quiet($sformatf("abort.post%0d", i));
        end
        build_table(1, -1);
        run_table("after_abort");

        // One-column frame: every pixel after the first carries Line
        b_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            b_start = 1'b0;
            chk($sformatf("col1[%0d].pixel", c), int'(b_pixel), (c >= 3 && c <= 5) ? 16 * (c - 3) : 0);
            chk($sformatf("col1[%0d].frame", c), int'(b_frame), int'(c == 3));
            chk($sformatf("col1[%0d].line",  c), int'(b_line),  int'(c == 4 || c == 5));
            chk($sformatf("col1[%0d].done",  c), int'(b_done),  int'(c == 5));
            chk($sformatf("col1[%0d].busy",  c), int'(b_busy),  int'(c <= 5));
            chk($sformatf("col1[%0d].rden",  c), int'(b_rden),  int'(c <= 3));
        end

        // Randomized 160x120 run with coordinate recovery from the strobes
        cyc = 0;
        rec_i = 0;
        rec_j = 0;
        starts.delete();
        for (int n = 0; n < 45000; n++) begin
            if (n % 4096 == 0) c_cont = ($urandom_range(0, 2) != 0);
            c_start = ($urandom_range(0, 29) == 0);
            if (!model_busy(cyc) && c_start)
                starts.push_back(cyc + 1);
            else if (starts.size() > 0 && cyc == starts[starts.size() - 1] + C_N - 1 && c_cont)
                starts.push_back(cyc + 1);
            if (starts.size() > 2) void'(starts.pop_front());
            step();
            cyc++;
            k = model_k(cyc);
            if (c_frame) begin
                rec_i = 0; rec_j = 0;
            end else if (c_line) begin
                rec_i = 0; rec_j++;
            end else begin
                rec_i++;
            end
            chk($sformatf("rnd[%0d].busy", cyc), int'(c_busy), int'(model_busy(cyc)));
            chk($sformatf("rnd[%0d].rden", cyc), int'(c_rden), int'(model_rden(cyc)));
            chk($sformatf("rnd[%0d].frame", cyc), int'(c_frame), int'(k == 0));
            chk($sformatf("rnd[%0d].line", cyc), int'(c_line), int'(k > 0 && k % int'(C_COLS) == 0));
            chk($sformatf("rnd[%0d].done", cyc), int'(c_done), int'(k == C_N - 1));
            if (k >= 0) begin
                chk($sformatf("rnd[%0d].pixel", cyc), int'(c_pixel), mem_c(k % int'(C_COLS), k / int'(C_COLS)));
                chk($sformatf("rnd[%0d].coord_i", cyc), rec_i, k % int'(C_COLS));
                chk($sformatf("rnd[%0d].coord_j", cyc), rec_j, k / int'(C_COLS));
            end else begin
                chk($sformatf("rnd[%0d].pixel", cyc), int'(c_pixel), 0);
            end
        end
        c_start = 1'b0;
        c_cont  = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
